// File: rtl/hs_mem_arbiter_if.sv
// rtl/hs_mem_arbiter_if.sv - bus bundle between the hiscore RAM arbiter, its requesters and the RAM byte port
interface hs_mem_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    // Bridge byte bus
    logic              b_rd;
    logic              b_wr;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wr_data;
    logic              b_ack;
    logic              b_rd_data_valid;

    // Signature scanner (read only)
    logic              s_rd;
    logic [ADDR_W-1:0] s_addr;
    logic              s_ack;
    logic              s_rd_data_valid;

    // Shared read data
    logic [DATA_W-1:0] rd_data;

    // RAM byte port and CPU ownership
    logic [ADDR_W-1:0] mem_address;
    logic              mem_write_enable;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;
    logic              processor_halt;
    logic              busy;

    // Arbiter side
    modport slave (
        input  b_rd, b_wr, b_addr, b_wr_data,
        output b_ack, b_rd_data_valid,
        input  s_rd, s_addr,
        output s_ack, s_rd_data_valid,
        output rd_data,
        output mem_address, mem_write_enable, mem_data_in,
        input  mem_data_out,
        output processor_halt, busy
    );

    // Requester / RAM environment side
    modport master (
        output b_rd, b_wr, b_addr, b_wr_data,
        input  b_ack, b_rd_data_valid,
        output s_rd, s_addr,
        input  s_ack, s_rd_data_valid,
        input  rd_data,
        input  mem_address, mem_write_enable, mem_data_in,
        output mem_data_out,
        input  processor_halt, busy
    );
endinterface

// File: rtl/hs_mem_arbiter.sv
// rtl/hs_mem_arbiter.sv - halts the game CPU and shares the hiscore RAM byte port between bridge and scanner
module hs_mem_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 8,
    parameter int HALT_SETTLE  = 4,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic            jb_core_clk,
    input  logic            reset,
    hs_mem_arbiter_if.slave bus
);
    localparam int SW = $clog2(HALT_SETTLE + 1);
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(HALT_SETTLE - 1);
    localparam logic [SW-1:0] SETTLE_MAX  = SW'(HALT_SETTLE);
    localparam logic [IW-1:0] IDLE_LAST   = IW'(IDLE_TIMEOUT - 1);
    localparam logic [IW-1:0] IDLE_MAX    = IW'(IDLE_TIMEOUT);

    typedef enum logic [1:0] {
        CPU_OWN = 2'd0,
        HALT    = 2'd1,
        SERVE   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic [IW-1:0]   idle_q, idle_d;
    logic            last_s_q, last_s_d;   // 1: scanner held the last grant
    logic            halt_q, halt_d;
    logic            b_vld_q, b_vld_d;
    logic            s_vld_q, s_vld_d;

    logic            b_req;
    logic            s_req;
    logic            any_req;
    logic            grant_b;
    logic            grant_s;

    logic            b_ack_c;
    logic            s_ack_c;
    logic            wen_c;
    logic [ADDR_W-1:0] addr_c;
    logic [DATA_W-1:0] wdata_c;

    // A pending write takes the bridge slot first; a simultaneous read stays pending
    assign b_req   = bus.b_rd | bus.b_wr;
    assign s_req   = bus.s_rd;
    assign any_req = b_req | s_req;
    assign grant_b = b_req & (~s_req | last_s_q);
    assign grant_s = s_req & ~grant_b;

    // State, counters, round-robin pointer and registered outputs
    always_ff @(posedge jb_core_clk or posedge reset) begin
        if (reset) begin
            state_q  <= CPU_OWN;
            settle_q <= '0;
            idle_q   <= '0;
            last_s_q <= 1'b1;
            halt_q   <= 1'b0;
            b_vld_q  <= 1'b0;
            s_vld_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            idle_q   <= idle_d;
            last_s_q <= last_s_d;
            halt_q   <= halt_d;
            b_vld_q  <= b_vld_d;
            s_vld_q  <= s_vld_d;
        end
    end

    // Next-state: take the RAM on demand, settle, serve until idle timeout
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        idle_d   = idle_q;
        last_s_d = last_s_q;
        case (state_q)
            CPU_OWN: begin
                settle_d = '0;
                idle_d   = '0;
                if (any_req) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                idle_d = '0;
                if (settle_q >= SETTLE_LAST) begin
                    state_d  = SERVE;
                    settle_d = '0;
                end else if (settle_q != SETTLE_MAX) begin
                    settle_d = settle_q + SW'(1);
                end
            end
            SERVE: begin
                settle_d = '0;
                if (any_req) begin
                    idle_d   = '0;
                    last_s_d = grant_s;
                end else if (idle_q >= IDLE_LAST) begin
                    state_d = CPU_OWN;
                    idle_d  = '0;
                end else if (idle_q != IDLE_MAX) begin
                    idle_d = idle_q + IW'(1);
                end
            end
            default: begin
                state_d = CPU_OWN;
            end
        endcase
        halt_d  = (state_d != CPU_OWN);
        b_vld_d = b_ack_c & ~wen_c;
        s_vld_d = s_ack_c;
    end

    // Outputs: drive the RAM port for the granted requester only while serving
    always_comb begin
        b_ack_c = 1'b0;
        s_ack_c = 1'b0;
        wen_c   = 1'b0;
        addr_c  = '0;
        wdata_c = '0;
        if (state_q == SERVE) begin
            if (grant_b) begin
                b_ack_c = 1'b1;
                addr_c  = bus.b_addr;
                wen_c   = bus.b_wr;
                wdata_c = bus.b_wr ? bus.b_wr_data : '0;
            end else if (grant_s) begin
                s_ack_c = 1'b1;
                addr_c  = bus.s_addr;
            end
        end
    end

    assign bus.b_ack            = b_ack_c;
    assign bus.s_ack            = s_ack_c;
    assign bus.b_rd_data_valid  = b_vld_q;
    assign bus.s_rd_data_valid  = s_vld_q;
    assign bus.rd_data          = bus.mem_data_out;
    assign bus.mem_address      = addr_c;
    assign bus.mem_write_enable = wen_c;
    assign bus.mem_data_in      = wdata_c;
    assign bus.processor_halt   = halt_q;
    assign bus.busy             = (state_q != CPU_OWN);
endmodule
